// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares a single-port 16x8 register unit between two
// requesters. It runs one transaction at a time through IDLE -> ISSUE ->
// (CAPT) -> ACK. It sequences the unit's load/store strobes, captures read
// data and returns a one-cycle ack to the requester that owns the transaction.
// Optional feature: define RR_ARB_EN for round-robin tie breaking. Without it,
// requester 0 has fixed priority.
module regfile_port_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              rf_load,
    output logic              rf_store,
    output logic [ADDR_W-1:0] rf_load_addr,
    output logic [ADDR_W-1:0] rf_store_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                we_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                busy_q;
    logic                rf_load_q;
    logic                rf_store_q;
    logic [ADDR_W-1:0]   rf_load_addr_q;
    logic [ADDR_W-1:0]   rf_store_addr_q;
    logic [DATA_W-1:0]   rf_data_in_q;
`ifdef RR_ARB_EN
    logic                last_grant_q;
`endif

    logic                grant_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // Pick the winner among the pending requests seen in IDLE.
    always_comb begin
        grant_d = 1'b0;
`ifdef RR_ARB_EN
        if (req0 && req1) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = req1;
        end
`else
        grant_d = ~req0;
`endif
    end

    // Select the winning requester's command fields.
    always_comb begin
        we_d    = grant_d ? we1    : we0;
        addr_d  = grant_d ? addr1  : addr0;
        wdata_d = grant_d ? wdata1 : wdata0;
    end

    // Transaction sequencer. Every output is loaded here for the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            we_q            <= 1'b0;
            ack0_q          <= 1'b0;
            ack1_q          <= 1'b0;
            rdata0_q        <= '0;
            rdata1_q        <= '0;
            busy_q          <= 1'b0;
            rf_load_q       <= 1'b0;
            rf_store_q      <= 1'b0;
            rf_load_addr_q  <= '0;
            rf_store_addr_q <= '0;
            rf_data_in_q    <= '0;
`ifdef RR_ARB_EN
            last_grant_q    <= 1'b1;
`endif
        end else begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rf_load_q  <= 1'b0;
            rf_store_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= grant_d;
                        we_q    <= we_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                        if (we_d) begin
                            rf_store_q      <= 1'b1;
                            rf_store_addr_q <= addr_d;
                            rf_data_in_q    <= wdata_d;
                        end else begin
                            rf_load_q       <= 1'b1;
                            rf_load_addr_q  <= addr_d;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        ack0_q  <= ~owner_q;
                        ack1_q  <= owner_q;
                        state_q <= ACK;
                    end else begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    if (owner_q) begin
                        rdata1_q <= rf_data_out;
                    end else begin
                        rdata0_q <= rf_data_out;
                    end
                    ack0_q  <= ~owner_q;
                    ack1_q  <= owner_q;
                    state_q <= ACK;
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef RR_ARB_EN
                    last_grant_q <= owner_q;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign busy          = busy_q;
    assign rf_load       = rf_load_q;
    assign rf_store      = rf_store_q;
    assign rf_load_addr  = rf_load_addr_q;
    assign rf_store_addr = rf_store_addr_q;
    assign rf_data_in    = rf_data_in_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter. It contains a register-unit model, a
// transaction-level reference model that is compared with the DUT every cycle,
// and directed tests whose expected values are worked out by hand.
module tb_regfile_port_arbiter;

`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, rf_load, rf_store;
    logic [7:0] rdata0, rdata1, rf_data_in;
    logic [3:0] rf_load_addr, rf_store_addr;
    logic [7:0] rf_data_out;
    logic       mem_init = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    regfile_port_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .rf_load(rf_load), .rf_store(rf_store),
        .rf_load_addr(rf_load_addr), .rf_store_addr(rf_store_addr),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register unit: the read data appears one cycle after load.
    logic [7:0] rf_mem [16];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
            rf_data_out <= 8'h00;
        end else begin
            if (rf_store) rf_mem[rf_store_addr] <= rf_data_in;
            if (rf_load)  rf_data_out <= rf_mem[rf_load_addr];
        end
    end

    // Reference model. m_k counts the cycles since the grant. Its value is 0
    // when idle and 1 in the strobe cycle. The ack falls in cycle 2 for a
    // write and in cycle 3 for a read.
    int         m_k = 0;
    int         m_owner = 0;
    int         m_last = 1;
    logic       m_we = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_mem [16];
    logic [7:0] m_rd [2];
    logic [3:0] m_la = '0, m_sa = '0;
    logic [7:0] m_di = '0;
    int         w_t;
    logic       we_t;
    logic [3:0] a_t;
    logic [7:0] d_t;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_k <= 0; m_owner <= 0; m_last <= 1; m_we <= 1'b0;
            m_rd[0] <= 8'h00; m_rd[1] <= 8'h00;
            m_la <= '0; m_sa <= '0; m_di <= '0;
            if (mem_init) for (int i = 0; i < 16; i++) m_mem[i] <= 8'h00;
        end else if (m_k == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) w_t = (RR && m_last == 0) ? 1 : 0;
                else              w_t = req0 ? 0 : 1;
                we_t = (w_t == 0) ? we0 : we1;
                a_t  = (w_t == 0) ? addr0 : addr1;
                d_t  = (w_t == 0) ? wdata0 : wdata1;
                m_owner <= w_t; m_last <= w_t; m_we <= we_t;
                m_addr <= a_t; m_wdata <= d_t; m_k <= 1;
                if (we_t) begin m_sa <= a_t; m_di <= d_t; end
                else      m_la <= a_t;
            end
        end else begin
            if (m_k == 1 && m_we)  m_mem[m_addr] <= m_wdata;
            if (m_k == 2 && !m_we) m_rd[m_owner] <= m_mem[m_addr];
            m_k <= (m_k == (m_we ? 2 : 3)) ? 0 : m_k + 1;
        end
    end

    // Compare every output with the model each cycle, away from the clock edge.
    int len_t;
    always @(negedge clock) begin
        len_t = m_we ? 2 : 3;
        chk("busy",      busy,     m_k != 0);
        chk("rf_load",   rf_load,  m_k == 1 && !m_we);
        chk("rf_store",  rf_store, m_k == 1 && m_we);
        chk("excl",      rf_load & rf_store, 0);
        chk("ack0",      ack0,     m_k == len_t && m_owner == 0);
        chk("ack1",      ack1,     m_k == len_t && m_owner == 1);
        chk("rdata0",    rdata0,   m_rd[0]);
        chk("rdata1",    rdata1,   m_rd[1]);
        chk("ld_addr",   rf_load_addr,  m_la);
        chk("st_addr",   rf_store_addr, m_sa);
        chk("data_in",   rf_data_in,    m_di);
    end

    logic [7:0] sb [16];

    // Issue one request from an idle cycle. Check the strobe, the ack latency
    // and the read data, and drop the request at drop_cyc when that is >= 0.
    task automatic run_one(input int who, input logic we, input logic [3:0] a,
                           input logic [7:0] d, input int drop_cyc, input string tag);
        int cyc;
        bit got;
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clock);
            cyc++;
            if (cyc == drop_cyc) begin req0 = 1'b0; req1 = 1'b0; end
            if (cyc == 1) begin
                if (we) begin
                    chk({tag, "_store"}, rf_store, 1);
                    chk({tag, "_staddr"}, rf_store_addr, a);
                    chk({tag, "_din"}, rf_data_in, d);
                end else begin
                    chk({tag, "_load"}, rf_load, 1);
                    chk({tag, "_ldaddr"}, rf_load_addr, a);
                end
            end
            if (((who == 0) ? ack0 : ack1) === 1'b1) got = 1'b1;
        end
        chk({tag, "_latency"}, got ? cyc : 99, we ? 2 : 3);
        if (got && !we) chk({tag, "_rdata"}, (who == 0) ? rdata0 : rdata1, sb[a]);
        if (got && we) sb[a] = d;
    endtask

    initial begin
        int order [4];
        int n;
        int cyc;
        for (int i = 0; i < 16; i++) sb[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_rdata0", rdata0, 8'h00);
        chk("rst_rdata1", rdata1, 8'h00);
        chk("rst_strobes", {rf_load, rf_store, ack0, ack1}, 4'b0000);
        mem_init = 1'b0;
        reset = 1'b1;

        // 1: write by 0, then read back by 1.
        run_one(0, 1'b1, 4'd3, 8'hA5, -1, "t1_wr");
        run_one(1, 1'b0, 4'd3, 8'h00, -1, "t1_rd");
        chk("t1_rdata1_lit", rdata1, 8'hA5);

        // 2: both requests held high as reads of 1 and 2.
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (ack0 === 1'b1) begin order[n] = 0; n++; end
            else if (ack1 === 1'b1) begin order[n] = 1; n++; end
        end
        chk("t2_acks", n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_grant%0d", i), (i < n) ? order[i] : 9, RR ? (i % 2) : 0);
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;

        // 3: reset during the capture cycle of a read.
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        @(negedge clock);
        @(negedge clock);
        chk("t3_busy_capt", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("t3_busy", busy, 0);
        chk("t3_ack", {ack0, ack1}, 2'b00);
        chk("t3_rdata0", rdata0, 8'h00);
        chk("t3_rdata1", rdata1, 8'h00);
        req0 = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        run_one(0, 1'b0, 4'd3, 8'h00, -1, "t3_after");
        chk("t3_rdata0_lit", rdata0, 8'hA5);

        // 4: read request withdrawn during the strobe cycle.
        run_one(1, 1'b0, 4'd3, 8'h00, 1, "t4_drop");

        // 5: random mixed operations.
        for (int i = 0; i < 20; i++)
            run_one($urandom_range(0, 1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)), -1, $sformatf("t5_%0d", i));

        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
